// File: rtl/spi_flash_responder_if.sv
// SPI link plus word-read port between the SPI flash responder and its environment.
interface spi_flash_responder_if;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        rd_en;
  logic [21:0] rd_addr;
  logic [31:0] rd_data;
  logic        cmd_err;

  // Responder side: consumes SPI pins and read data, drives MISO and read requests.
  modport slave (
    input  spi_sck,
    input  spi_ss,
    input  spi_mosi,
    input  rd_data,
    output spi_miso,
    output rd_en,
    output rd_addr,
    output cmd_err
  );

  // Environment side: SPI master plus the word memory.
  modport master (
    output spi_sck,
    output spi_ss,
    output spi_mosi,
    output rd_data,
    input  spi_miso,
    input  rd_en,
    input  rd_addr,
    input  cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash responder: decodes mode-0 READ (0x03 + 24-bit address) and streams bytes
// from a 32-bit little-endian word memory on MISO, prefetching the next word.
module spi_flash_responder (
  input logic                   clock,
  input logic                   reset,
  spi_flash_responder_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

  // Synchronizer / edge-detect chains; index 1 is the synced value, index 2 the delayed copy.
  logic [2:0] sck_sr, ss_sr;
  logic [1:0] mosi_sr;

  logic sck_rise, sck_fall, ss_fall, ss_high, mosi_s;

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  byte_ptr_q, byte_ptr_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [31:0] next_buf_q, next_buf_d;
  logic        miso_q, miso_d;
  logic        rd_en_q, rd_en_d;
  logic [21:0] rd_addr_q, rd_addr_d;
  logic        cmd_err_q, cmd_err_d;
  // rd_vld marks the cycle rd_data is valid; rd_dst selects word_buf (0) or next_buf (1).
  logic        rd_vld_q, rd_vld_d;
  logic        rd_dst_q, rd_dst_d;

  logic [7:0]  cmd_shift;
  logic [23:0] addr_shift;
  logic [7:0]  cur_byte;

  // Two-flop synchronizers plus a third flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sr  <= '0;
      ss_sr   <= '0;
      mosi_sr <= '0;
    end else begin
      sck_sr  <= {sck_sr[1:0], bus.spi_sck};
      ss_sr   <= {ss_sr[1:0], bus.spi_ss};
      mosi_sr <= {mosi_sr[0], bus.spi_mosi};
    end
  end

  assign sck_rise   = sck_sr[1] & ~sck_sr[2];
  assign sck_fall   = ~sck_sr[1] & sck_sr[2];
  assign ss_fall    = ~ss_sr[1] & ss_sr[2];
  assign ss_high    = ss_sr[1];
  assign mosi_s     = mosi_sr[1];
  assign cmd_shift  = {cmd_q[6:0], mosi_s};
  assign addr_shift = {addr_q[22:0], mosi_s};
  assign cur_byte   = word_buf_q[{byte_ptr_q, 3'b000} +: 8];

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      byte_ptr_q <= '0;
      bit_idx_q  <= 3'd7;
      word_buf_q <= '0;
      next_buf_q <= '0;
      miso_q     <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      cmd_err_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_dst_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      byte_ptr_q <= byte_ptr_d;
      bit_idx_q  <= bit_idx_d;
      word_buf_q <= word_buf_d;
      next_buf_q <= next_buf_d;
      miso_q     <= miso_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      cmd_err_q  <= cmd_err_d;
      rd_vld_q   <= rd_vld_d;
      rd_dst_q   <= rd_dst_d;
    end
  end

  // Next-state, command/address decode, byte streaming and prefetch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    byte_ptr_d = byte_ptr_q;
    bit_idx_d  = bit_idx_q;
    word_buf_d = word_buf_q;
    next_buf_d = next_buf_q;
    miso_d     = miso_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    cmd_err_d  = 1'b0;
    rd_vld_d   = rd_en_q;
    rd_dst_d   = rd_dst_q;

    // Read data lands one cycle after the request, whatever state we are in by then.
    if (rd_vld_q) begin
      if (rd_dst_q) next_buf_d = bus.rd_data;
      else          word_buf_d = bus.rd_data;
    end

    if (ss_high) begin
      state_d   = StIdle;
      miso_d    = 1'b1;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          miso_d    = 1'b1;
          bit_cnt_d = '0;
          if (ss_fall) state_d = StCmd;
        end
        StCmd: begin
          miso_d = 1'b1;
          if (sck_rise) begin
            cmd_d = cmd_shift;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (cmd_shift == 8'h03) begin
                state_d = StAddr;
              end else begin
                cmd_err_d = 1'b1;
                state_d   = StIgnore;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        StAddr: begin
          miso_d = 1'b1;
          if (sck_rise) begin
            addr_d = addr_shift;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              rd_en_d    = 1'b1;
              rd_addr_d  = addr_shift[23:2];
              rd_dst_d   = 1'b0;
              byte_ptr_d = addr_shift[1:0];
              bit_idx_d  = 3'd7;
              state_d    = StData;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        StData: begin
          if (sck_fall) begin
            miso_d = cur_byte[bit_idx_q];
            // Starting the last lane of a word: fetch the following word.
            if (bit_idx_q == 3'd7 && byte_ptr_q == 2'd3) begin
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_q + 22'd1;
              rd_dst_d  = 1'b1;
            end
            if (bit_idx_q == 3'd0) begin
              bit_idx_d  = 3'd7;
              byte_ptr_d = byte_ptr_q + 2'd1;
              if (byte_ptr_q == 2'd3) word_buf_d = next_buf_q;
            end else begin
              bit_idx_d = bit_idx_q - 3'd1;
            end
          end
        end
        StIgnore: begin
          miso_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
          miso_d  = 1'b1;
        end
      endcase
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI master tasks, a word memory, and a byte-address
// reference model of the expected MISO stream and read requests.
module tb_spi_flash_responder;

  localparam int H = 6;  // SCK half period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b1;

  spi_flash_responder_if bus ();

  spi_flash_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] seed;
  logic [31:0] mem [logic [21:0]];
  logic [21:0] rd_q[$];
  int          err_cnt;
  logic [7:0]  last_rx[$];

  function automatic logic [31:0] mem_word(input logic [21:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0], ~wa[15:0]} ^ seed;
  endfunction

  // Byte at a flat byte address, little-endian lanes.
  function automatic logic [7:0] byte_at(input logic [23:0] b);
    logic [31:0] w;
    w = mem_word(b[23:2]);
    return w[{b[1:0], 3'b000} +: 8];
  endfunction

  // Word memory: data valid the cycle after rd_en.
  always @(posedge clock) begin
    if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr);
  end

  // Monitor read requests and command errors.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.rd_en) rd_q.push_back(bus.rd_addr);
      if (bus.cmd_err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      repeat (H) @(negedge clock);
      rx[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      repeat (H) @(negedge clock);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic ss_start();
    rd_q.delete();
    err_cnt = 0;
    bus.spi_ss = 1'b0;
    repeat (H) @(negedge clock);
  endtask

  task automatic ss_end();
    bus.spi_ss = 1'b1;
    repeat (2 * H) @(negedge clock);
  endtask

  // Full READ of n bytes from byte address a, checked against the model.
  task automatic do_read(input logic [23:0] a, input int n);
    logic [31:0] rx;
    logic [23:0] b;
    logic [21:0] exp_rd[$];
    last_rx.delete();
    ss_start();
    xfer(32'h03, 8, rx);
    xfer({8'h00, a}, 24, rx);
    exp_rd.push_back(a[23:2]);
    // Each byte started in lane 3 (including the one begun by the final fall) prefetches.
    for (int k = 0; k <= n; k++) begin
      b = a + 24'(k);
      if (b[1:0] == 2'd3) exp_rd.push_back(b[23:2] + 22'd1);
    end
    for (int k = 0; k < n; k++) begin
      xfer(32'h0, 8, rx);
      last_rx.push_back(rx[7:0]);
      check("rd_byte", 64'(rx[7:0]), 64'(byte_at(a + 24'(k))));
    end
    repeat (2 * H) @(negedge clock);
    ss_end();
    check("rd_count", 64'(rd_q.size()), 64'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++)
      check("rd_addr", 64'(rd_q[k]), 64'(exp_rd[k]));
    check("no_cmd_err", 64'(err_cnt), 64'd0);
  endtask

  initial begin
    logic [31:0] rx;
    seed         = $urandom;
    bus.spi_sck  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.rd_data  = '0;
    err_cnt      = 0;
    repeat (3) @(negedge clock);
    check("rst_miso", 64'(bus.spi_miso), 64'd1);
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rst_cmd_err", 64'(bus.cmd_err), 64'd0);
    reset = 1'b0;
    repeat (2 * H) @(negedge clock);

    // Basic aligned read
    mem[22'h0] = 32'h44332211;
    do_read(24'h000000, 4);
    check("basic_b0", 64'(last_rx[0]), 64'h11);
    check("basic_b3", 64'(last_rx[3]), 64'h44);

    // Unaligned across a word boundary
    mem[22'h100] = 32'hDDCCBBAA;
    mem[22'h101] = 32'h87654321;
    do_read(24'h000402, 4);
    check("unal_b0", 64'(last_rx[0]), 64'hCC);
    check("unal_b2", 64'(last_rx[2]), 64'h21);
    check("unal_b3", 64'(last_rx[3]), 64'h43);

    // Address wrap at the top of memory
    mem[22'h3FFFFF] = 32'h5A6B7C8D;
    do_read(24'hFFFFFF, 2);
    check("wrap_b0", 64'(last_rx[0]), 64'h5A);
    check("wrap_b1", 64'(last_rx[1]), 64'h11);

    // Bad command: one cmd_err, MISO idle high, no reads
    ss_start();
    xfer(32'h0B, 8, rx);
    check("bad_cmd_miso", 64'(rx[7:0]), 64'hFF);
    repeat (4) @(negedge clock);
    check("bad_cmd_err", 64'(err_cnt), 64'd1);
    xfer(32'h03000000, 32, rx);
    check("ignore_miso_a", 64'(rx), 64'hFFFFFFFF);
    xfer(32'hA5, 8, rx);
    check("ignore_miso_b", 64'(rx[7:0]), 64'hFF);
    check("bad_cmd_err_once", 64'(err_cnt), 64'd1);
    check("bad_cmd_no_rd", 64'(rd_q.size()), 64'd0);
    ss_end();
    do_read(24'h000000, 4);

    // Abort after 12 address bits
    ss_start();
    xfer(32'h03, 8, rx);
    xfer(32'h000, 12, rx);
    ss_end();
    check("abort_no_rd", 64'(rd_q.size()), 64'd0);
    mem[22'h1] = 32'hF1E2D3C4;
    do_read(24'h000004, 4);
    check("abort_next_b0", 64'(last_rx[0]), 64'hC4);

    // Reset mid-DATA with SS held low
    ss_start();
    xfer(32'h03, 8, rx);
    xfer(32'h000400, 24, rx);
    xfer(32'h0, 16, rx);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_miso", 64'(bus.spi_miso), 64'd1);
    check("midrst_rd_en", 64'(bus.rd_en), 64'd0);
    check("midrst_rd_addr", 64'(bus.rd_addr), 64'd0);
    reset = 1'b0;
    rd_q.delete();
    err_cnt = 0;
    xfer(32'h03000000, 32, rx);
    check("midrst_quiet_miso", 64'(rx), 64'hFFFFFFFF);
    check("midrst_quiet_rd", 64'(rd_q.size()), 64'd0);
    check("midrst_quiet_err", 64'(err_cnt), 64'd0);
    ss_end();
    do_read(24'h000401, 5);

    // Randomized reads
    for (int t = 0; t < 6; t++) begin
      do_read(24'($urandom), int'($urandom_range(1, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI flash responder: the device end of the SPI link driven by the SoC's APB SPI master. It decodes mode-0 SPI read transactions (command 0x03 plus 24-bit address) and streams bytes from a 32-bit word-wide read port back on MISO. The bench instantiates it as the flash model behind the master's flash chip-select when SPI transfers are simulated rather than skipped. All SPI inputs are oversampled on the single system clock.

## Interface
- No parameters.
- clock      in   1   system clock; all logic on rising edge
- reset      in   1   asynchronous, active-high reset
- spi_sck    in   1   SPI clock from master, CPOL=0
- spi_ss     in   1   chip select, active-low
- spi_mosi   in   1   master-to-responder data, MSB first
- spi_miso   out  1   responder-to-master data, MSB first
- rd_en      out  1   one-cycle read request to word memory
- rd_addr    out  22  word address (byte address [23:2])
- rd_data    in   32  read data, valid exactly 1 cycle after rd_en; little-endian byte lanes
- cmd_err    out  1   one-cycle pulse when a received command is not 0x03

## Operation
- Input sync: spi_sck, spi_ss, spi_mosi each pass through a 2-flop synchronizer. The spi_ss flops reset to 0 (asserted); spi_sck and spi_mosi flops reset to 0. A third flop on synced sck/ss gives edge detection: sck_rise, sck_fall, ss_fall.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: waits for synced ss high followed by ss_fall, then goes to CMD with bit_cnt=0. A start while ss is already low after reset is not detected.
- CMD: on each sck_rise, shift synced MOSI into cmd[7:0]. After the 8th bit:
  - cmd==0x03: go to ADDR.
  - otherwise: pulse cmd_err and go to IGNORE.
- ADDR: on each sck_rise, shift into addr[23:0]. After the 24th bit:
  - pulse rd_en with rd_addr=addr[23:2]; capture rd_data the next cycle into word_buf.
  - byte_ptr=addr[1:0]; go to DATA.
- DATA:
  - Each sck_fall drives spi_miso with the next bit of the current byte. The current byte is word_buf[8*byte_ptr +: 8], bit 7 first.
  - After bit 0 of a byte has been driven, the next sck_fall starts the next byte and byte_ptr increments mod 4.
  - When byte_ptr==3 starts, issue rd_en for word address+1, wrapping 0x3FFFFF to 0. Hold the data in next_buf and move it to word_buf when byte_ptr wraps to 0.
  - Streaming continues indefinitely while ss stays low.
- IGNORE: spi_miso=1 until ss deasserts.
- Synced ss high in any state: go to IDLE the same cycle and set spi_miso=1. Partial command or address bits are discarded.
- spi_miso=1 in IDLE, CMD, ADDR and IGNORE.
- sck edges are ignored while synced ss is high.

## Timing
- Reset values:
  - spi_miso=1, rd_en=0, rd_addr=0, cmd_err=0
  - state=IDLE, bit_cnt=0, word_buf=0, next_buf=0
- Input-to-detect latency: 3 clock cycles from a pin transition to the edge pulse.
- SCK constraint: high and low phases each >= 4 clock cycles (SCK period >= 8 clocks). This guarantees:
  - the first word is in word_buf before the first data sck_fall: rd_en at cycle t, data at t+1, fall detected no earlier than t+4;
  - the prefetch completes well before the word boundary.
- rd_en is a single-cycle pulse. No more than one read is outstanding.
- spi_miso updates 1 cycle after sck_fall detection, i.e. 4 clocks after the pin edge. It is stable before the master's next rising edge.
- cmd_err asserts the cycle after the 8th command bit is detected.
- Reset asserted mid-transaction: outputs return to reset values immediately. Service resumes only after ss goes high, then low again.

## Test plan
- Basic read: memory word 0 = 0x44332211, ss low, send 0x03, 0x000000, clock 32 more bits -> rd_en once with rd_addr=0; MISO returns 0x11,0x22,0x33,0x44; prefetch rd_addr=1 issued while 0x44 starts.
- Unaligned stream: word 0x100 = 0xDDCCBBAA, word 0x101 = 0x87654321, address 0x000402, 4 bytes -> 0xCC,0xDD,0x21,0x43 with no gap at the word boundary.
- Wrap: address 0xFFFFFF -> first byte is word 0x3FFFFF lane 3; prefetch rd_addr=0; next byte is word 0 lane 0.
- Bad command: send 0x0B -> cmd_err pulses once, no rd_en, MISO held 1 for 40 further SCKs. A following correct transaction after ss high then low succeeds.
- Abort: deassert ss after 12 address bits -> state IDLE, no rd_en. The next full read of address 0x000004 returns word 1 bytes.
- Reset mid-DATA with ss still low -> MISO=1, rd_en=0, no response until ss toggles high then low. The subsequent read is correct.
